nms_window_scheduler: RTL and testbench

- Sequences the 3x3 non-maximum-suppression corner check over a raster-order stream of signed Harris response values, one frame at a time.
- Owns two line buffers and the 3x3 window registers, and tracks pixel and row counters.
- Applies the threshold-and-local-maximum test and emits one flagged result per interior pixel, with coordinates.
- Sits between the Harris response stage and the corner-list writer; uses valid/ready handshakes on both sides.

---
 rtl/nms_window_scheduler.sv | 123 ++++++++++++
 tb/tb_nms_window_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/nms_window_scheduler.sv
// nms_window_scheduler: streams raster Harris responses through two line buffers and a 3x3 window, emitting one thresholded local-maximum flag per interior pixel.
module nms_window_scheduler #(
  parameter int                 DATA_W = 64,
  parameter int                 IMG_W  = 64,
  parameter int                 IMG_H  = 64,
  parameter logic signed [63:0] THRESH = 64'h0000_0001_0000_0000,
  parameter int                 XY_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_corner_o,
  output logic [XY_W-1:0]   out_x_o,
  output logic [XY_W-1:0]   out_y_o,
  output logic              busy_o,
  output logic              frame_done_o
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [XY_W-1:0] LAST_X = XY_W'(IMG_W - 1);
  localparam logic [XY_W-1:0] LAST_Y = XY_W'(IMG_H - 1);
  localparam logic signed [DATA_W-1:0] THR = DATA_W'(THRESH);

  logic [1:0] state_q, state_d;
  logic [XY_W-1:0] col_q, col_d, row_q, row_d;
  logic out_valid_q, out_corner_q;
  logic [XY_W-1:0] out_x_q, out_y_q;
  logic signed [DATA_W-1:0] lb1_q [IMG_W];
  logic signed [DATA_W-1:0] lb2_q [IMG_W];
  // win_q[row][0] is column x-2, win_q[row][1] is column x-1; column x arrives live
  logic signed [DATA_W-1:0] win_q [3][2];
  logic signed [DATA_W-1:0] col_n [3];
  logic signed [DATA_W-1:0] nb [8];
  logic signed [DATA_W-1:0] mid;
  logic [AW-1:0] idx;
  logic accept, produce, last_x, last_y, is_max, corner;

  assign idx          = col_q[AW-1:0];
  assign in_ready_o   = (state_q == S_STREAM) && (!out_valid_q || out_ready_i);
  assign accept       = in_valid_i && in_ready_o;
  assign last_x       = col_q == LAST_X;
  assign last_y       = row_q == LAST_Y;
  assign produce      = accept && (col_q >= XY_W'(2)) && (row_q >= XY_W'(2));
  assign out_valid_o  = out_valid_q;
  assign out_corner_o = out_corner_q;
  assign out_x_o      = out_x_q;
  assign out_y_o      = out_y_q;
  assign busy_o       = state_q != S_IDLE;
  assign frame_done_o = state_q == S_DONE;

  always_comb begin
    col_n = '{lb2_q[idx], lb1_q[idx], $signed(in_data_i)};
    mid   = win_q[1][1];
    nb    = '{win_q[0][0], win_q[1][0], win_q[2][0], win_q[0][1], win_q[2][1],
              col_n[0], col_n[1], col_n[2]};
    is_max = 1'b1;
    for (int i = 0; i < 8; i++) is_max = is_max && (mid > nb[i]);
    corner = is_max && (mid > THR);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_STREAM;
        col_d   = '0;
        row_d   = '0;
      end
      S_STREAM: if (accept) begin
        col_d   = last_x ? '0 : col_q + XY_W'(1);
        row_d   = last_x ? row_q + XY_W'(1) : row_q;
        state_d = (last_x && last_y) ? S_DRAIN : S_STREAM;
      end
      S_DRAIN: state_d = (!out_valid_q || out_ready_i) ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_corner_q <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (produce) begin
        out_valid_q  <= 1'b1;
        out_corner_q <= corner;
        out_x_q      <= col_q - XY_W'(1);
        out_y_q      <= row_q - XY_W'(1);
      end else if (out_ready_i) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb2_q[idx] <= lb1_q[idx];
      lb1_q[idx] <= $signed(in_data_i);
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= col_n[r];
      end
    end
  end
endmodule

// File: tb/tb_nms_window_scheduler.sv
// tb_nms_window_scheduler: directed 5x5 frames with hand-computed corner masks, plus backpressure, reset and ignored-input sequences.
module tb_nms_window_scheduler;
  localparam int W = 5;
  localparam int H = 5;
  localparam int NRES = (W - 2) * (H - 2);

  typedef struct {
    logic signed [63:0] bg;
    int ax, ay;
    logic signed [63:0] av;
    int bx, by;
    logic signed [63:0] bv;
    logic [8:0] mask;
    bit stall;
    bit poke;
  } vec_t;

  logic clk = 0, reset_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [63:0] in_data = '0;
  logic in_ready, out_valid, out_corner, busy, frame_done;
  logic [15:0] out_x, out_y;
  logic signed [63:0] pix [W*H];
  vec_t vecs [6];
  int checks = 0, errors = 0;

  nms_window_scheduler #(.DATA_W(64), .IMG_W(W), .IMG_H(H),
    .THRESH(64'h0000_0001_0000_0000), .XY_W(16)) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_corner_o(out_corner), .out_x_o(out_x),
    .out_y_o(out_y), .busy_o(busy), .frame_done_o(frame_done));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_cleared(input string nm);
    check({nm, " in_ready"}, {63'd0, in_ready}, 64'd0);
    check({nm, " out_valid"}, {63'd0, out_valid}, 64'd0);
    check({nm, " out_corner"}, {63'd0, out_corner}, 64'd0);
    check({nm, " out_xy"}, {32'd0, out_x, out_y}, 64'd0);
    check({nm, " busy"}, {63'd0, busy}, 64'd0);
    check({nm, " frame_done"}, {63'd0, frame_done}, 64'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_frame(input vec_t v);
    int idx, nres, cyc, stalls, dones, extra;
    logic [32:0] snap;
    logic acc;
    for (int i = 0; i < W*H; i++) pix[i] = v.bg;
    pix[v.ay*W + v.ax] = v.av;
    pix[v.by*W + v.bx] = v.bv;
    if (v.poke) begin
      @(negedge clk);
      in_valid = 1;
      in_data  = 64'h1234;
      out_ready = 1;
      repeat (4) begin
        @(negedge clk);
        #1;
        check("idle in_ready", {63'd0, in_ready}, 64'd0);
        check("idle busy/out_valid", {62'd0, busy, out_valid}, 64'd0);
      end
      in_valid = 0;
    end
    pulse_start();
    #1;
    check("busy after start", {63'd0, busy}, 64'd1);
    idx = 0; nres = 0; cyc = 0; stalls = 0; dones = 0; extra = 0;
    while ((idx < W*H || nres < NRES) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      in_valid  = idx < W*H;
      in_data   = (idx < W*H) ? pix[idx] : 64'd0;
      start     = v.poke && (idx == 7);
      out_ready = 1;
      if (v.stall && out_valid && stalls < 10) out_ready = 0;
      #1;
      if (frame_done) dones++;
      if (!out_ready) begin
        if (stalls == 0) snap = {out_corner, out_x, out_y};
        else check("stall hold", {31'd0, out_corner, out_x, out_y}, {31'd0, snap});
        check("stall in_ready", {63'd0, in_ready}, 64'd0);
        stalls++;
      end
      if (out_valid && out_ready) begin
        if (nres < NRES)
          check($sformatf("result %0d corner/x/y", nres),
                {31'd0, out_corner, out_x, out_y},
                {31'd0, v.mask[nres], 16'(1 + nres % 3), 16'(1 + nres / 3)});
        else extra++;
        nres++;
      end
      acc = in_valid && in_ready;
      if (acc) idx++;
    end
    start = 0; in_valid = 0; out_ready = 1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (frame_done) dones++;
      if (out_valid) extra++;
    end
    check("result count", 64'(nres), 64'(NRES));
    check("extra results", 64'(extra), 64'd0);
    check("frame_done pulses", 64'(dones), 64'd1);
    check("idle after frame", {63'd0, busy}, 64'd0);
    if (v.stall) check("stall cycles", 64'(stalls), 64'd10);
  endtask

  initial begin
    vecs[0] = '{bg:0, ax:2, ay:2, av:64'sh2_0000_0000, bx:2, by:2, bv:64'sh2_0000_0000, mask:9'h010, stall:0, poke:0};
    vecs[1] = '{bg:0, ax:2, ay:2, av:64'sh1_0000_0000, bx:2, by:2, bv:64'sh1_0000_0000, mask:9'h000, stall:0, poke:0};
    vecs[2] = '{bg:0, ax:2, ay:2, av:64'sh2_0000_0000, bx:3, by:3, bv:64'sh2_0000_0000, mask:9'h000, stall:0, poke:0};
    vecs[3] = '{bg:-64'sd1, ax:2, ay:2, av:64'sh1_0000_0001, bx:2, by:2, bv:64'sh1_0000_0001, mask:9'h010, stall:0, poke:0};
    vecs[4] = '{bg:0, ax:1, ay:1, av:64'sh5_0000_0000, bx:1, by:1, bv:64'sh5_0000_0000, mask:9'h001, stall:1, poke:1};
    vecs[5] = '{bg:0, ax:3, ay:1, av:64'sh3_0000_0000, bx:1, by:3, bv:64'sh3_0000_0000, mask:9'h044, stall:0, poke:0};
    #2;
    check_cleared("in reset");
    @(negedge clk);
    reset_n = 1;
    for (int t = 0; t < 6; t++) run_frame(vecs[t]);
    pulse_start();
    out_ready = 0;
    for (int i = 0; i < W*H; i++) pix[i] = (i == 2*W + 2) ? 64'sh2_0000_0000 : 64'sd0;
    begin
      int n = 0, cyc = 0;
      while (n < 13 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        in_valid = 1;
        in_data  = pix[n];
        #1;
        if (in_ready) n++;
      end
      @(negedge clk);
      in_valid = 0;
      #1;
      check("pre-reset accepts", 64'(n), 64'd13);
      check("pre-reset pending", {31'd0, out_valid, out_x, out_y}, {31'd0, 1'b1, 16'd1, 16'd1});
    end
    reset_n = 0;
    #1;
    check_cleared("mid-frame reset");
    @(negedge clk);
    reset_n = 1;
    out_ready = 1;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("post-reset idle", {62'd0, busy, frame_done}, 64'd0);
    end
    run_frame(vecs[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
